// File: rtl/hdc_pkg.sv
// ---------------------------------------------------------------------------
// hdc_pkg
// Shared constants and types for the hypervector pruning datapath.
//   HV_DIM          : total hypervector dimensions
//   DIMS_PER_CC     : dimensions carried per chunk / per cycle
//   SEQ_CYCLE_COUNT : chunks per hypervector
//   CHUNK_IDX_W     : width of a chunk index
//   KEPT_CNT_W      : width of a kept-dimension count over a full vector
//   POP_CNT_W       : width of a kept-dimension count over one chunk
// ---------------------------------------------------------------------------
package hdc_pkg;

  localparam int HV_DIM          = 4096;
  localparam int DIMS_PER_CC     = 1024;
  localparam int SEQ_CYCLE_COUNT = HV_DIM / DIMS_PER_CC;
  localparam int CHUNK_IDX_W     = $clog2(SEQ_CYCLE_COUNT);
  localparam int KEPT_CNT_W      = $clog2(HV_DIM + 1);
  localparam int POP_CNT_W       = $clog2(DIMS_PER_CC + 1);

  localparam logic [CHUNK_IDX_W-1:0] LAST_CHUNK_IDX = CHUNK_IDX_W'(SEQ_CYCLE_COUNT - 1);
  localparam logic [DIMS_PER_CC-1:0] MASK_ALL_ONES  = {DIMS_PER_CC{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_READY   = 2'd2
  } prune_store_state_t;

endpackage

// File: rtl/popcount_chunk.sv
// ---------------------------------------------------------------------------
// popcount_chunk
// Combinational population count of one mask chunk.
// Ports:
//   bits  : WIDTH-bit input vector
//   count : number of set bits in bits
// ---------------------------------------------------------------------------
module popcount_chunk #(
  parameter int WIDTH = 1024,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] bits,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_s;

  // Sum of all set bits; synthesis folds this into an adder tree.
  always_comb begin
    count_s = {CNT_W{1'b0}};
    for (int i = 0; i < WIDTH; i++) begin
      count_s = count_s + {{(CNT_W-1){1'b0}}, bits[i]};
    end
  end

  assign count = count_s;

endmodule

// File: rtl/prune_mask_store.sv
// ---------------------------------------------------------------------------
// prune_mask_store
// Captures the per-chunk enable masks from the pruning controller into a
// full HV_DIM-bit mask and serves chunks back on request. Until a complete
// mask is held, reads return all ones (nothing pruned).
//
// Build option: define PRUNE_CNT_EN to compile in the kept-dimension
// counter; without it kept_count is constant zero.
//
// Ports:
//   clk, nrst   : clock (rising edge), asynchronous active-low reset
//   start       : begin / restart capture of a new mask
//   in_valid    : in_mask carries the next chunk
//   in_mask     : enable chunk (1 = keep dimension)
//   rd_en       : read request, rd_idx selects the chunk
//   rd_valid    : rd_mask valid, one cycle after rd_en
//   rd_mask     : requested chunk (all ones while no complete mask)
//   mask_ready  : complete mask stored
//   busy        : capture in progress
//   done        : one-cycle pulse when the last chunk is stored
//   kept_count  : kept dimensions of the mask being / last captured
// ---------------------------------------------------------------------------
module prune_mask_store
  import hdc_pkg::*;
(
  input  logic                   clk,
  input  logic                   nrst,
  input  logic                   start,
  input  logic                   in_valid,
  input  logic [DIMS_PER_CC-1:0] in_mask,
  input  logic                   rd_en,
  input  logic [CHUNK_IDX_W-1:0] rd_idx,
  output logic                   rd_valid,
  output logic [DIMS_PER_CC-1:0] rd_mask,
  output logic                   mask_ready,
  output logic                   busy,
  output logic                   done,
  output logic [KEPT_CNT_W-1:0]  kept_count
);

  prune_store_state_t state_r;
  prune_store_state_t state_next_s;

  logic [CHUNK_IDX_W-1:0] chunk_cnt_r;
  logic [DIMS_PER_CC-1:0] bank_r [SEQ_CYCLE_COUNT];

  logic accept_s;
  logic accept_last_s;
  logic busy_next_s;
  logic mask_ready_next_s;

  logic                   busy_r;
  logic                   mask_ready_r;
  logic                   done_r;
  logic                   rd_valid_r;
  logic [DIMS_PER_CC-1:0] rd_mask_r;

  // Chunk acceptance: only while capturing, and a same-cycle start wins.
  always_comb begin
    accept_s      = 1'b0;
    accept_last_s = 1'b0;
    if ((state_r == ST_CAPTURE) && in_valid && !start) begin
      accept_s      = 1'b1;
      accept_last_s = (chunk_cnt_r == LAST_CHUNK_IDX);
    end else begin
      accept_s      = 1'b0;
      accept_last_s = 1'b0;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_next_s = ST_CAPTURE;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_CAPTURE: begin
        if (start) begin
          state_next_s = ST_CAPTURE;
        end else if (accept_last_s) begin
          state_next_s = ST_READY;
        end else begin
          state_next_s = ST_CAPTURE;
        end
      end
      ST_READY: begin
        if (start) begin
          state_next_s = ST_CAPTURE;
        end else begin
          state_next_s = ST_READY;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // FSM output decode, taken from the next state so the status registers
  // change on the same edge as the state itself.
  always_comb begin
    busy_next_s       = 1'b0;
    mask_ready_next_s = 1'b0;
    case (state_next_s)
      ST_CAPTURE: begin
        busy_next_s       = 1'b1;
        mask_ready_next_s = 1'b0;
      end
      ST_READY: begin
        busy_next_s       = 1'b0;
        mask_ready_next_s = 1'b1;
      end
      default: begin
        busy_next_s       = 1'b0;
        mask_ready_next_s = 1'b0;
      end
    endcase
  end

  // Status registers and the done pulse.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      busy_r       <= 1'b0;
      mask_ready_r <= 1'b0;
      done_r       <= 1'b0;
    end else begin
      busy_r       <= busy_next_s;
      mask_ready_r <= mask_ready_next_s;
      done_r       <= accept_last_s;
    end
  end

  // Write pointer: cleared by start, advanced per accepted chunk.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      chunk_cnt_r <= {CHUNK_IDX_W{1'b0}};
    end else if (start) begin
      chunk_cnt_r <= {CHUNK_IDX_W{1'b0}};
    end else if (accept_s) begin
      if (accept_last_s) begin
        chunk_cnt_r <= {CHUNK_IDX_W{1'b0}};
      end else begin
        chunk_cnt_r <= chunk_cnt_r + {{(CHUNK_IDX_W-1){1'b0}}, 1'b1};
      end
    end
  end

  // Mask storage: plain data registers, overwritten in place, never reset.
  always_ff @(posedge clk) begin
    if (accept_s) begin
      bank_r[chunk_cnt_r] <= in_mask;
    end
  end

  // Read port: readiness is judged on the pre-edge flag, so a read in the
  // cycle the last chunk lands still returns the no-pruning mask.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      rd_valid_r <= 1'b0;
      rd_mask_r  <= MASK_ALL_ONES;
    end else if (rd_en) begin
      rd_valid_r <= 1'b1;
      rd_mask_r  <= mask_ready_r ? bank_r[rd_idx] : MASK_ALL_ONES;
    end else begin
      rd_valid_r <= 1'b0;
    end
  end

`ifdef PRUNE_CNT_EN
  logic [POP_CNT_W-1:0]  chunk_pop_s;
  logic [KEPT_CNT_W-1:0] kept_count_r;

  popcount_chunk #(
    .WIDTH (DIMS_PER_CC),
    .CNT_W (POP_CNT_W)
  ) u_popcount (
    .bits  (in_mask),
    .count (chunk_pop_s)
  );

  // Kept-dimension accumulator; HV_DIM fits the width so no saturation.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      kept_count_r <= {KEPT_CNT_W{1'b0}};
    end else if (start) begin
      kept_count_r <= {KEPT_CNT_W{1'b0}};
    end else if (accept_s) begin
      kept_count_r <= kept_count_r + {{(KEPT_CNT_W-POP_CNT_W){1'b0}}, chunk_pop_s};
    end
  end

  assign kept_count = kept_count_r;
`else
  assign kept_count = {KEPT_CNT_W{1'b0}};
`endif

  assign rd_valid   = rd_valid_r;
  assign rd_mask    = rd_mask_r;
  assign mask_ready = mask_ready_r;
  assign busy       = busy_r;
  assign done       = done_r;

endmodule

// File: tb/tb_prune_mask_store.sv
// ---------------------------------------------------------------------------
// tb_prune_mask_store
// Directed bench for prune_mask_store with a transaction-level reference:
// the reference collects accepted chunks in a queue and only publishes them
// as the mask once a full vector has arrived. Follows PRUNE_CNT_EN the same
// way the design does for the expected kept_count.
// ---------------------------------------------------------------------------
module tb_prune_mask_store;
  import hdc_pkg::*;

  logic                   clk = 1'b0;
  logic                   nrst;
  logic                   start;
  logic                   in_valid;
  logic [DIMS_PER_CC-1:0] in_mask;
  logic                   rd_en;
  logic [CHUNK_IDX_W-1:0] rd_idx;
  logic                   rd_valid;
  logic [DIMS_PER_CC-1:0] rd_mask;
  logic                   mask_ready;
  logic                   busy;
  logic                   done;
  logic [KEPT_CNT_W-1:0]  kept_count;

  prune_mask_store dut (
    .clk        (clk),
    .nrst       (nrst),
    .start      (start),
    .in_valid   (in_valid),
    .in_mask    (in_mask),
    .rd_en      (rd_en),
    .rd_idx     (rd_idx),
    .rd_valid   (rd_valid),
    .rd_mask    (rd_mask),
    .mask_ready (mask_ready),
    .busy       (busy),
    .done       (done),
    .kept_count (kept_count)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

`ifdef PRUNE_CNT_EN
  localparam int EXP_KEPT2 = 1537;
  localparam int EXP_KEPT3 = 1037;
`else
  localparam int EXP_KEPT2 = 0;
  localparam int EXP_KEPT3 = 0;
`endif

  localparam logic [DIMS_PER_CC-1:0] ONES  = {DIMS_PER_CC{1'b1}};
  localparam logic [DIMS_PER_CC-1:0] ZEROS = {DIMS_PER_CC{1'b0}};

  logic [DIMS_PER_CC-1:0] c_chunk [4];
  logic [DIMS_PER_CC-1:0] e_chunk [4];

  // Reference model state
  bit                     m_capturing;
  bit                     m_ready;
  bit                     m_done;
  bit                     m_rdv;
  int                     m_kept;
  logic [DIMS_PER_CC-1:0] m_rdmask;
  logic [DIMS_PER_CC-1:0] m_bank [4];
  logic [DIMS_PER_CC-1:0] m_pending [$];

  function automatic int kept_of(logic [DIMS_PER_CC-1:0] v);
`ifdef PRUNE_CNT_EN
    return $countones(v);
`else
    return 0;
`endif
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_mask(string name, logic [DIMS_PER_CC-1:0] act, logic [DIMS_PER_CC-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got low64 %h expected low64 %h (t=%0t)", name, act[63:0], exp[63:0], $time);
    end
  endtask

  task automatic model_reset();
    m_capturing = 1'b0;
    m_ready     = 1'b0;
    m_done      = 1'b0;
    m_rdv       = 1'b0;
    m_kept      = 0;
    m_rdmask    = ONES;
    m_pending.delete();
  endtask

  // One clock edge of the reference, in terms of the observable contract.
  task automatic model_step(bit s, bit v, logic [DIMS_PER_CC-1:0] d, bit r, int ix);
    m_done = 1'b0;
    m_rdv  = r;
    if (r) m_rdmask = m_ready ? m_bank[ix] : ONES;
    if (s) begin
      m_capturing = 1'b1;
      m_ready     = 1'b0;
      m_kept      = 0;
      m_pending.delete();
    end else if (m_capturing && v) begin
      m_pending.push_back(d);
      m_kept += kept_of(d);
      if (m_pending.size() == 4) begin
        for (int i = 0; i < 4; i++) m_bank[i] = m_pending[i];
        m_pending.delete();
        m_capturing = 1'b0;
        m_ready     = 1'b1;
        m_done      = 1'b1;
      end
    end
  endtask

  // Advance one clock, feeding the reference the inputs seen at the edge.
  task automatic tick();
    bit s, v, r;
    logic [DIMS_PER_CC-1:0] d;
    int ix;
    s  = start;
    v  = in_valid;
    d  = in_mask;
    r  = rd_en;
    ix = int'(rd_idx);
    @(posedge clk);
    if (nrst) model_step(s, v, d, r, ix);
    #1;
  endtask

  // Cycle-by-cycle comparison against the reference.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_rd_valid", 64'(rd_valid), 64'(m_rdv));
      chk_mask("cyc_rd_mask", rd_mask, m_rdmask);
      chk("cyc_mask_ready", 64'(mask_ready), 64'(m_ready));
      chk("cyc_busy", 64'(busy), 64'(m_capturing));
      chk("cyc_done", 64'(done), 64'(m_done));
      chk("cyc_kept", 64'(kept_count), 64'(m_kept));
    end
  end

  initial begin
    c_chunk[0] = ONES;
    c_chunk[1] = ZEROS;
    c_chunk[2] = {(DIMS_PER_CC/4){4'hA}};
    c_chunk[3] = {{(DIMS_PER_CC-1){1'b0}}, 1'b1};
    e_chunk[0] = {{(DIMS_PER_CC-4){1'b0}}, 4'hF};
    e_chunk[1] = {{(DIMS_PER_CC-8){1'b0}}, 8'hFF};
    e_chunk[2] = ONES;
    e_chunk[3] = {1'b1, {(DIMS_PER_CC-1){1'b0}}};

    nrst     = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    in_mask  = ZEROS;
    rd_en    = 1'b0;
    rd_idx   = {CHUNK_IDX_W{1'b0}};
    model_reset();
    repeat (2) tick();
    nrst   = 1'b1;
    chk_en = 1'b1;

    // Reset state
    chk("rst_rd_valid", 64'(rd_valid), 64'd0);
    chk_mask("rst_rd_mask", rd_mask, ONES);
    chk("rst_mask_ready", 64'(mask_ready), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_kept", 64'(kept_count), 64'd0);

    // Read before any mask exists
    rd_en = 1'b1; rd_idx = 2'd2;
    tick();
    rd_en = 1'b0;
    chk("s1_rd_valid", 64'(rd_valid), 64'd1);
    chk_mask("s1_rd_mask", rd_mask, ONES);
    tick();
    chk("s1_rd_valid_drop", 64'(rd_valid), 64'd0);

    // Full capture, with a read in the cycle the last chunk lands
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("s2_busy", 64'(busy), 64'd1);
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_mask  = c_chunk[i];
      if (i == 3) begin
        rd_en = 1'b1; rd_idx = 2'd0;
      end
      tick();
    end
    in_valid = 1'b0;
    rd_en    = 1'b0;
    chk("s2_done", 64'(done), 64'd1);
    chk("s2_ready", 64'(mask_ready), 64'd1);
    chk("s2_busy_end", 64'(busy), 64'd0);
    chk("s2_kept", 64'(kept_count), 64'(EXP_KEPT2));
    chk_mask("s2_rd_during_last", rd_mask, ONES);
    tick();
    chk("s2_done_pulse", 64'(done), 64'd0);
    for (int i = 0; i < 4; i++) begin
      rd_en  = 1'b1;
      rd_idx = CHUNK_IDX_W'(i);
      tick();
      chk_mask("s2_rd_chunk", rd_mask, c_chunk[i]);
    end
    rd_en = 1'b0;
    tick();
    chk_mask("s2_rd_hold", rd_mask, c_chunk[3]);

    // Restart mid-capture with a colliding in_valid, then gapped chunks
    start = 1'b1;
    tick();
    start = 1'b0;
    in_valid = 1'b1; in_mask = ONES;               tick();
    in_valid = 1'b1; in_mask = {256{4'h5}};        tick();
    start = 1'b1; in_valid = 1'b1; in_mask = ONES; tick();
    start = 1'b0; in_valid = 1'b0;
    chk("s3_kept_cleared", 64'(kept_count), 64'd0);
    chk("s3_busy", 64'(busy), 64'd1);
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_mask  = e_chunk[i];
      tick();
      in_valid = 1'b0;
      if (i == 1) repeat (2) tick();
    end
    chk("s3_done", 64'(done), 64'd1);
    chk("s3_kept", 64'(kept_count), 64'(EXP_KEPT3));
    for (int i = 0; i < 4; i++) begin
      rd_en  = 1'b1;
      rd_idx = CHUNK_IDX_W'(i);
      tick();
      chk_mask("s3_rd_chunk", rd_mask, e_chunk[i]);
    end
    rd_en = 1'b0;

    // in_valid while READY must be ignored
    in_valid = 1'b1; in_mask = ZEROS;
    repeat (2) tick();
    in_valid = 1'b0;
    chk("s4_no_done", 64'(done), 64'd0);
    chk("s4_kept_held", 64'(kept_count), 64'(EXP_KEPT3));
    rd_en = 1'b1; rd_idx = 2'd1;
    tick();
    rd_en = 1'b0;
    chk_mask("s4_rd_unchanged", rd_mask, e_chunk[1]);

    // Reset after the third chunk of a new capture
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_mask  = c_chunk[i];
      tick();
    end
    in_valid = 1'b0;
    nrst = 1'b0;
    model_reset();
    #1;
    chk("s5_ready", 64'(mask_ready), 64'd0);
    chk("s5_busy", 64'(busy), 64'd0);
    chk("s5_kept", 64'(kept_count), 64'd0);
    tick();
    nrst = 1'b1;

    // in_valid while IDLE must be ignored; reads give the no-pruning mask
    in_valid = 1'b1; in_mask = ZEROS;
    repeat (2) tick();
    in_valid = 1'b0;
    chk("s5_idle_busy", 64'(busy), 64'd0);
    chk("s5_idle_done", 64'(done), 64'd0);
    rd_en = 1'b1; rd_idx = 2'd1;
    tick();
    rd_en = 1'b0;
    chk("s5_rd_valid", 64'(rd_valid), 64'd1);
    chk_mask("s5_rd_ones", rd_mask, ONES);
    repeat (2) tick();

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/prune_mask_store.md
# prune_mask_store

Downstream stage of the random-projection pruning controller. It captures the per-dimension enable chunks (1 = keep dimension, 0 = pruned) that the controller emits once per cycle over a full hypervector pass, assembles them into a complete HV_DIM-bit pruning mask, and optionally counts the kept dimensions. It then serves mask chunks on request to the encoder/similarity datapath. Until a complete mask exists, it returns an all-ones (no-pruning) mask.

## Interface
- HV_DIM, 4096, total hypervector dimensions
- DIMS_PER_CC, 1024, dimensions per chunk/cycle
- SEQ_CYCLE_COUNT, 4, chunks per hypervector (HV_DIM/DIMS_PER_CC)
- clk  in  1  clock, rising edge
- nrst  in  1  reset, asynchronous, active-low
- start  in  1  pulse; begin (or restart) capture of a new mask
- in_valid  in  1  in_mask carries the next chunk
- in_mask  in  DIMS_PER_CC  enable chunk from pruning controller
- rd_en  in  1  read request
- rd_idx  in  $clog2(SEQ_CYCLE_COUNT)  chunk index to read
- rd_valid  out  1  rd_mask valid (1 cycle after rd_en)
- rd_mask  out  DIMS_PER_CC  requested mask chunk
- mask_ready  out  1  complete mask stored
- busy  out  1  capture in progress
- done  out  1  one-cycle pulse when last chunk stored
- kept_count  out  $clog2(HV_DIM+1)  number of kept dimensions (13 b by default)

## Operation
- FSM states: IDLE, CAPTURE, READY. Reset → IDLE.
- IDLE: start → CAPTURE. in_valid ignored.
- CAPTURE: busy=1. Each in_valid writes in_mask to bank[chunk_cnt], chunk_cnt++. When the write is for chunk SEQ_CYCLE_COUNT-1 → READY, done=1 for one cycle. Gaps between in_valid are allowed.
- READY: mask_ready=1. start → CAPTURE, mask_ready drops, chunk_cnt=0, kept_count=0. in_valid ignored.
- start in CAPTURE restarts the capture: chunk_cnt=0, kept_count=0. A simultaneous in_valid is dropped (start wins).
- Reads: rd_en sampled in any state. rd_valid=1 on the next cycle. rd_mask = bank[rd_idx] if mask_ready was 1 at sampling, else all ones. Without rd_en, rd_valid=0 and rd_mask holds its last value.
- kept_count (with PRUNE_CNT_EN): on each accepted chunk, kept_count += popcount(in_mask). Saturation is never needed (max HV_DIM fits). Value is held until the next start.
- Banks are not cleared by start, only overwritten. Banks are not reset (data regs). All control registers are reset.

## Timing
- Reset values: rd_valid=0, rd_mask=all ones, mask_ready=0, busy=0, done=0, kept_count=0, chunk_cnt=0.
- start at edge t: busy=1 from t+1.
- Last chunk accepted at edge t: done=1, mask_ready=1, busy=0 and final kept_count are all visible after edge t (same cycle).
- Read latency is 1 cycle, full throughput (back-to-back rd_en supported).
- rd_en in the cycle the last chunk is written returns all ones (mask_ready was still 0 when sampled).
- nrst mid-capture: immediate return to IDLE, partial mask discarded, outputs return to reset values.

## Configuration
- PRUNE_CNT_EN defined: popcount adder and kept_count register are compiled in.
- PRUNE_CNT_EN undefined: no popcount logic; kept_count is tied to 0; all other behaviour is unchanged.

## Structure
- Shared package hdc_pkg: HV_DIM, DIMS_PER_CC, SEQ_CYCLE_COUNT defaults, CHUNK_IDX_W, KEPT_CNT_W, FSM state enum prune_store_state_t.
- Sub-module popcount_chunk: combinational DIMS_PER_CC-bit popcount, output $clog2(DIMS_PER_CC+1) bits. Instantiated only under PRUNE_CNT_EN.

## Test plan
- Reset, then rd_en with rd_idx=2 → next cycle rd_valid=1, rd_mask=all ones, mask_ready=0, kept_count=0.
- start, then 4 chunks with in_valid (all ones, all zeros, 0x…AAAA alternating, single bit 0 set) → done pulse after 4th, kept_count=1024+0+512+1=1537, reads of idx 0..3 return the exact chunks.
- start, 2 chunks, start again (in_valid high on same cycle), 4 new chunks → only the new chunks are stored, kept_count counts the new chunks only.
- in_valid pulses while IDLE and while READY → no bank change, kept_count unchanged, no done.
- nrst asserted after 3rd chunk → mask_ready=0, busy=0; a subsequent read returns all ones.
- Build without PRUNE_CNT_EN, repeat scenario 2 → kept_count=0, mask contents identical.
